pingpong_frame_ram: RTL and testbench
=====================================

Name: pingpong_frame_ram

Overview:
- Parametrised double-buffered successor to the team's single-bank 8-bit simple dual-port M10K store.
- Holds two banks of 2^ADDR_W words each. The writer fills one bank while the reader scans the other.
- Banks exchange through a swap handshake that is gated by a reader frame-boundary strobe.
- Sits between the frame producer (compute/DMA side) and the display scan-out logic.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 15, per-bank address width. Total storage is 2 * 2^ADDR_W words.
- RD_LAT, 1, read latency in cycles. Legal values are 1 or 2; 2 adds an output register stage.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wren  in  1  write request into the current write bank.
- wraddress  in  ADDR_W  write address within the bank.
- data  in  DATA_W  write data.
- wr_ready  out  1  writes are accepted. Low while a swap is pending.
- rden  in  1  read request from the current read bank.
- rdaddress  in  ADDR_W  read address within the bank.
- q  out  DATA_W  read data.
- q_valid  out  1  q holds data for a read issued RD_LAT cycles earlier.
- swap_req  in  1  single-cycle pulse: writer has finished its frame.
- rd_sync  in  1  reader is at a frame boundary (e.g. vsync start).
- swap_ack  out  1  one-cycle pulse, the cycle after a swap executes.
- wr_bank  out  1  bank currently written.
- rd_bank  out  1  bank currently read. Always equal to ~wr_bank.
- rd_frame_valid  out  1  read bank holds a completed frame.
- wr_count  out  ADDR_W+1  writes accepted since the last swap, saturating.

Behaviour:
- Reset values (reset_n=0 at a clock edge): q=0, q_valid=0, wr_ready=1, swap_ack=0, wr_bank=0, rd_bank=1, rd_frame_valid=0, wr_count=0, state=IDLE. RAM contents are not reset.
- Physical address = {bank, addr}. Memory is inferred as M10K with no read/write collision check.
- Write: the write is accepted when wren & wr_ready at an edge. It lands at {wr_bank, wraddress}, and wr_count increments, saturating at 2^(ADDR_W+1)-1. A write attempted while wr_ready=0 is dropped and not counted.
- Read, bank capture: rden at edge t captures rd_bank together with rdaddress.
- Read, output timing: q updates at edge t+RD_LAT and q_valid=1 for that cycle. If no read completes, q holds its value and q_valid=0.
- Reads are fully pipelined, one per cycle. The reader and writer never touch the same bank, so no collision is possible.
- FSM states:
  - IDLE: wr_ready=1. If swap_req & rd_sync, the swap executes at this edge. Else if swap_req, go to PENDING.
  - PENDING: wr_ready=0. swap_req is ignored. On rd_sync, the swap executes and the FSM returns to IDLE.
- Swap edge effects:
  - wr_bank and rd_bank toggle; wr_count clears to 0; rd_frame_valid becomes 1 and stays 1 until reset.
  - swap_ack=1 in the following cycle only.
- Simultaneous events:
  - wren & swap_req in IDLE: the write is accepted into the old write bank.
  - rden in the same cycle as a swap edge: the read uses the pre-swap rd_bank.
  - Reads in flight across a swap complete from the bank captured at issue.
- rd_sync without a pending request has no effect.
- Reset mid-operation: a pending swap is cancelled and banks return to wr=0/rd=1. Any in-flight q_valid is squashed to 0.

Decomposition:
- Shared package pingpong_pkg holds:
  - the FSM state typedef (IDLE, PENDING);
  - the localparam RD_LAT_MAX=2;
  - a function computing the wr_count saturation limit from ADDR_W.
- Sub-module dense_ram_core(DATA_W, AW=ADDR_W+1) is a single-bank simple dual-port RAM with registered read and an M10K ramstyle attribute.
- The top level holds the FSM, bank pointers, the counter, the optional second output stage, and the q_valid shift register.

Test Plan:
- Reset, then write addr 0x0005=0xA5 (bank 0), swap_req+rd_sync in the same cycle, then rden addr 0x0005 -> q=0xA5 with q_valid exactly RD_LAT cycles later; rd_bank=0; swap_ack pulses once.
- swap_req with rd_sync held low for 10 cycles, driving wren each cycle -> wr_ready=0 for all 10 cycles, wr_count unchanged, writes absent after swap; rd_sync -> swap, wr_ready=1 next cycle.
- Issue rden at addr 0x0010 on the swap edge, with bank1[0x0010]=0x11 and bank0[0x0010]=0x22 -> q=0x11 (pre-swap bank); the next read returns 0x22.
- Back-to-back reads addr 0..7 in RD_LAT=1 and RD_LAT=2 builds -> 8 consecutive q_valid cycles, in-order data, no bubbles.
- 2^(ADDR_W+1)+3 accepted writes without a swap -> wr_count saturates at 2^(ADDR_W+1)-1.
- Assert reset_n=0 while PENDING with a read in flight -> next cycle shows state IDLE, wr_bank=0, q_valid=0, wr_ready=1, rd_frame_valid=0.

Source files
------------

// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared definitions for the double-buffered frame store.
//   - pp_state_e       : swap handshake FSM states
//   - RD_LAT_MAX       : largest supported read latency
//   - wr_count_limit() : saturation value of the per-frame write counter
package pingpong_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pp_state_e;

  localparam int RD_LAT_MAX = 2;

  // The write counter is ADDR_W+1 bits wide and saturates at its all-ones value.
  function automatic int wr_count_limit(input int addr_w);
    return (1 << (addr_w + 1)) - 1;
  endfunction

endpackage

// File: rtl/dense_ram_core.sv
// dense_ram_core: single-bank simple dual-port RAM with a registered read.
//   clk    in   clock, all logic on the rising edge
//   rst_n  in   synchronous active-low reset (clears the read register only)
//   we     in   write enable
//   waddr  in   write address [AW]
//   wdata  in   write data [DATA_W]
//   re     in   read enable; rdata holds its value when low
//   raddr  in   read address [AW]
//   rdata  out  registered read data [DATA_W]
module dense_ram_core #(
  parameter int DATA_W = 8,
  parameter int AW     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // The two ports never address the same bank at once, so the collision
  // bypass logic is not needed.
  (* ramstyle = "M10K, no_rw_check" *) logic [DATA_W-1:0] mem [0:(2**AW)-1];

  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pingpong_frame_ram.sv
// pingpong_frame_ram: two-bank frame store. The writer fills wr_bank while
// the reader scans rd_bank (= ~wr_bank); banks exchange on a swap request
// that is held off until the reader reaches a frame boundary (rd_sync).
//   clock, reset_n            clock / synchronous active-low reset
//   wren, wraddress, data     write port into the current write bank
//   wr_ready                  low while a swap is pending (writes dropped)
//   rden, rdaddress           read port from the current read bank
//   q, q_valid                read data, valid RD_LAT edges after capture
//   swap_req, rd_sync         swap request pulse / reader frame boundary
//   swap_ack                  one-cycle pulse after the swap edge
//   wr_bank, rd_bank          current bank pointers
//   rd_frame_valid            read bank holds a completed frame
//   wr_count                  saturating count of accepted writes per frame
module pingpong_frame_ram
  import pingpong_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [DATA_W-1:0] data,
  output logic              wr_ready,
  input  logic              rden,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  input  logic              swap_req,
  input  logic              rd_sync,
  output logic              swap_ack,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              rd_frame_valid,
  output logic [ADDR_W:0]   wr_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] WR_CNT_MAX = CNT_W'(wr_count_limit(ADDR_W));

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("pingpong_frame_ram: RD_LAT must be 1 or 2");
  end

  pp_state_e         state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rfv_q, rfv_d;
  logic              swap_ack_q, swap_ack_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
  // vld_q[0]: read captured this edge; vld_q[k]: data k edges further along.
  logic [RD_LAT:0]   vld_q, vld_d;
  logic              swap_exec;
  logic              wr_accept;
  logic [DATA_W-1:0] ram_rdata;

  // Swap handshake
  always_comb begin
    state_d   = state_q;
    swap_exec = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_req) begin
          if (rd_sync) swap_exec = 1'b1;
          else         state_d   = PENDING;
        end
      end
      PENDING: begin
        if (rd_sync) begin
          swap_exec = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ready  = (state_q == IDLE);
  assign wr_accept = wren & wr_ready;

  always_comb begin
    wr_bank_d  = wr_bank_q ^ swap_exec;
    rfv_d      = rfv_q | swap_exec;
    swap_ack_d = swap_exec;
    wr_count_d = wr_count_q;
    // A write on the swap edge still lands in the old bank, but the counter
    // restarts for the new frame.
    if (swap_exec) begin
      wr_count_d = '0;
    end else if (wr_accept && (wr_count_q != WR_CNT_MAX)) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
    // Bank is captured with the address, so a read issued on the swap edge
    // or still in flight afterwards uses the bank it was issued against.
    rd_addr_d = rden ? {~wr_bank_q, rdaddress} : rd_addr_q;
    vld_d     = (RD_LAT + 1)'({vld_q, rden});
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_bank_q  <= 1'b0;
      rfv_q      <= 1'b0;
      swap_ack_q <= 1'b0;
      wr_count_q <= '0;
      rd_addr_q  <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rfv_q      <= rfv_d;
      swap_ack_q <= swap_ack_d;
      wr_count_q <= wr_count_d;
      rd_addr_q  <= rd_addr_d;
      vld_q      <= vld_d;
    end
  end

  dense_ram_core #(
    .DATA_W(DATA_W),
    .AW    (ADDR_W + 1)
  ) u_ram (
    .clk  (clock),
    .rst_n(reset_n),
    .we   (wr_accept),
    .waddr({wr_bank_q, wraddress}),
    .wdata(data),
    .re   (vld_q[0]),
    .raddr(rd_addr_q),
    .rdata(ram_rdata)
  );

  if (RD_LAT == 2) begin : g_out_stage
    logic [DATA_W-1:0] q2_q, q2_d;

    always_comb begin
      q2_d = vld_q[1] ? ram_rdata : q2_q;
    end

    always_ff @(posedge clock) begin
      if (!reset_n) q2_q <= '0;
      else          q2_q <= q2_d;
    end

    assign q = q2_q;
  end else begin : g_no_out_stage
    assign q = ram_rdata;
  end

  assign q_valid        = vld_q[RD_LAT];
  assign swap_ack       = swap_ack_q;
  assign wr_bank        = wr_bank_q;
  assign rd_bank        = ~wr_bank_q;
  assign rd_frame_valid = rfv_q;
  assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_pingpong_frame_ram.sv
// Testbench for pingpong_frame_ram: two instances (RD_LAT=1 and RD_LAT=2)
// share all stimulus; read results are checked against a per-instance queue.
module tb_pingpong_frame_ram;

  localparam int AW      = 6;
  localparam int DW      = 8;
  localparam int CW      = AW + 1;
  localparam int CNT_MAX = (1 << (AW + 1)) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, wren, rden, swap_req, rd_sync;
  logic [AW-1:0] wraddress, rdaddress;
  logic [DW-1:0] data;

  logic [DW-1:0] q_w   [2];
  logic          qv_w  [2];
  logic          wrr_w [2];
  logic          ack_w [2];
  logic          wb_w  [2];
  logic          rb_w  [2];
  logic          rfv_w [2];
  logic [CW-1:0] cnt_w [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    pingpong_frame_ram #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .RD_LAT(gi + 1)
    ) dut (
      .clock         (clk),
      .reset_n       (reset_n),
      .wren          (wren),
      .wraddress     (wraddress),
      .data          (data),
      .wr_ready      (wrr_w[gi]),
      .rden          (rden),
      .rdaddress     (rdaddress),
      .q             (q_w[gi]),
      .q_valid       (qv_w[gi]),
      .swap_req      (swap_req),
      .rd_sync       (rd_sync),
      .swap_ack      (ack_w[gi]),
      .wr_bank       (wb_w[gi]),
      .rd_bank       (rb_w[gi]),
      .rd_frame_valid(rfv_w[gi]),
      .wr_count      (cnt_w[gi])
    );
  end

  typedef struct packed {
    logic [7:0]  d;
    logic [31:0] e;
  } sb_t;

  sb_t         sb0[$];
  sb_t         sb1[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] ecnt  = 32'd0;

  always @(posedge clk) ecnt <= ecnt + 32'd1;

  // Scoreboard: every q_valid must match the oldest outstanding read, both
  // in data and in distance (edges) from the capturing edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      sb_t  x;
      logic have;
      if (qv_w[i] === 1'b1) begin
        total++;
        have = 1'b0;
        x    = '0;
        if (i == 0 && sb0.size() > 0) begin x = sb0.pop_front(); have = 1'b1; end
        if (i == 1 && sb1.size() > 0) begin x = sb1.pop_front(); have = 1'b1; end
        if (!have) begin
          bad++;
          $display("FAIL rd_unexpected dut%0d: got q_valid=1 q=%h, want no read outstanding", i, q_w[i]);
        end else if (q_w[i] !== x.d || (ecnt - x.e) != 32'(i + 1)) begin
          bad++;
          $display("FAIL rd_data dut%0d: got q=%h lat=%0d, want q=%h lat=%0d",
                   i, q_w[i], ecnt - x.e, x.d, i + 1);
        end else begin
          $display("read  dut%0d q=%h lat=%0d", i, q_w[i], i + 1);
        end
      end
    end
  end

  function automatic logic [5:0] st(input int i);
    return {wrr_w[i], ack_w[i], wb_w[i], rb_w[i], rfv_w[i], qv_w[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wren     = 1'b0;
    rden     = 1'b0;
    swap_req = 1'b0;
    rd_sync  = 1'b0;
  endtask

  task automatic issue_read(input logic [AW-1:0] a, input logic [7:0] exp);
    sb_t ent;
    rden      = 1'b1;
    rdaddress = a;
    ent.d     = exp;
    ent.e     = ecnt + 32'd1;
    sb0.push_back(ent);
    sb1.push_back(ent);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [7:0] d);
    wren      = 1'b1;
    wraddress = a;
    data      = d;
    tick();
    wren      = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    wraddress = '0;
    rdaddress = '0;
    data      = '0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (st(i) !== 6'b100100) begin
        bad++;
        $display("FAIL reset_status dut%0d: got %b want 100100", i, st(i));
      end
      total++;
      if (cnt_w[i] !== '0 || q_w[i] !== '0) begin
        bad++;
        $display("FAIL reset_cnt_q dut%0d: got cnt=%0d q=%h want 0/00", i, cnt_w[i], q_w[i]);
      end
    end
    $display("reset checked");
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [5:0] s;
    write_word(AW'(5), 8'hA5);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (cnt_w[i] !== CW'(1)) begin
        bad++;
        $display("FAIL wr_count_one dut%0d: got %0d want 1", i, cnt_w[i]);
      end
    end
    swap_req = 1'b1;
    rd_sync  = 1'b1;
    tick();
    swap_req = 1'b0;
    rd_sync  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (st(i) !== 6'b111010 || cnt_w[i] !== '0) begin
        bad++;
        $display("FAIL swap_status dut%0d: got %b cnt=%0d want 111010 cnt=0", i, st(i), cnt_w[i]);
      end
    end
    issue_read(AW'(5), 8'hA5);
    tick();
    rden = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (st(i) !== 6'b101010) begin
        bad++;
        $display("FAIL swap_ack_once dut%0d: got %b want 101010", i, st(i));
      end
    end
    rd_sync = 1'b1;
    tick();
    rd_sync = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = st(i);
      total++;
      if (s[5:1] !== 5'b10101) begin
        bad++;
        $display("FAIL lone_rd_sync dut%0d: got %b want 10101", i, s[5:1]);
      end
    end
    $display("basic swap done");
    repeat (3) tick();
  endtask

  task automatic test_pending();
    for (int k = 0; k < 10; k++) write_word(AW'(32 + k), 8'h3C);
    write_word(AW'(16), 8'h11);
    // swap request together with a write: the write still counts
    swap_req  = 1'b1;
    wren      = 1'b1;
    wraddress = AW'(42);
    data      = 8'h77;
    tick();
    swap_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wren      = 1'b1;
      wraddress = AW'(32 + k);
      data      = 8'(8'hE0 + k);
      swap_req  = (k == 4);
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (wrr_w[i] !== 1'b0 || cnt_w[i] !== CW'(12)) begin
          bad++;
          $display("FAIL pending_block dut%0d cyc%0d: got wr_ready=%b cnt=%0d want 0/12",
                   i, k, wrr_w[i], cnt_w[i]);
        end
      end
    end
    idle_inputs();
    rd_sync = 1'b1;
    tick();
    rd_sync = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (st(i) !== 6'b110110 || cnt_w[i] !== '0) begin
        bad++;
        $display("FAIL pending_swap dut%0d: got %b cnt=%0d want 110110 cnt=0", i, st(i), cnt_w[i]);
      end
    end
    for (int k = 0; k < 10; k++) begin
      issue_read(AW'(32 + k), 8'h3C);
      tick();
    end
    issue_read(AW'(42), 8'h77);
    tick();
    rden = 1'b0;
    $display("pending swap done");
    repeat (3) tick();
  endtask

  task automatic test_swap_edge_read();
    logic [5:0] s;
    write_word(AW'(16), 8'h22);
    swap_req = 1'b1;
    rd_sync  = 1'b1;
    issue_read(AW'(16), 8'h11);
    tick();
    swap_req = 1'b0;
    rd_sync  = 1'b0;
    issue_read(AW'(16), 8'h22);
    tick();
    rden = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = st(i);
      total++;
      if (s[3:2] !== 2'b10) begin
        bad++;
        $display("FAIL edge_banks dut%0d: got wr/rd=%b want 10", i, s[3:2]);
      end
    end
    $display("swap-edge read done");
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) write_word(AW'(k), 8'(8'h50 + k));
    swap_req = 1'b1;
    rd_sync  = 1'b1;
    tick();
    swap_req = 1'b0;
    rd_sync  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      issue_read(AW'(k), 8'(8'h50 + k));
      tick();
    end
    rden = 1'b0;
    repeat (4) tick();
    $display("back-to-back reads done");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < (1 << (AW + 1)) + 3; k++) begin
      wren      = 1'b1;
      wraddress = AW'(k);
      data      = 8'(k);
      tick();
      if (k == 125) begin
        for (int i = 0; i < 2; i++) begin
          total++;
          if (cnt_w[i] !== CW'(126)) begin
            bad++;
            $display("FAIL cnt_mid dut%0d: got %0d want 126", i, cnt_w[i]);
          end
        end
      end
    end
    wren = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (cnt_w[i] !== CW'(CNT_MAX)) begin
        bad++;
        $display("FAIL cnt_sat dut%0d: got %0d want %0d", i, cnt_w[i], CNT_MAX);
      end
    end
    $display("saturation done");
  endtask

  task automatic test_reset_mid();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (wrr_w[i] !== 1'b0) begin
        bad++;
        $display("FAIL enter_pending dut%0d: got wr_ready=%b want 0", i, wrr_w[i]);
      end
    end
    // read issued but expected to be squashed by the reset: not queued
    rden      = 1'b1;
    rdaddress = AW'(3);
    tick();
    rden    = 1'b0;
    reset_n = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (st(i) !== 6'b100100 || cnt_w[i] !== '0 || q_w[i] !== '0) begin
        bad++;
        $display("FAIL mid_reset dut%0d: got %b cnt=%0d q=%h want 100100 cnt=0 q=00",
                 i, st(i), cnt_w[i], q_w[i]);
      end
    end
    reset_n = 1'b1;
    tick();
    // RAM contents survive reset; read bank is bank 1 again
    issue_read(AW'(5), 8'h55);
    tick();
    rden = 1'b0;
    repeat (4) tick();
    $display("mid-operation reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pending();
    test_swap_edge_read();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    total++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      bad++;
      $display("FAIL rd_missing: got outstanding %0d/%0d want 0/0", sb0.size(), sb1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
